// File: rtl/ram_device_pkg.sv
// Shared definitions for the ram_device endpoint: bus pin indices, FSM states and decoded ops.
package ram_device_pkg;

  // Pin indices on the ram_ctrl / ram_stat words, shared with the motherboard RAM path.
  localparam int unsigned CtrlReadBit  = 0;
  localparam int unsigned CtrlWriteBit = 1;
  localparam int unsigned CtrlOpBits   = 2;
  localparam int unsigned StatAckBit   = 0;
  localparam int unsigned StatErrBit   = 1;
  localparam int unsigned StatBusyBit  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck
  } state_e;

  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic rd, input logic wr);
    return op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/ram_device_array.sv
// Single-port synchronous word array with registered read; swappable for a vendor RAM macro.
module ram_device_array #(
  parameter int unsigned WordWidth = 32,
  parameter int unsigned Depth     = 4096,
  parameter int unsigned AddrW     = 12
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     addr_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [WordWidth-1:0] rdata_o
);

  // Zero initial contents exist for simulation only; reset never clears the array.
  logic [WordWidth-1:0] mem [Depth] = '{default: '0};
  logic [WordWidth-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_device.sv
// Word-addressed RAM endpoint answering the four-phase ram_ctrl/ram_stat handshake with a
// fixed access latency; illegal ops and out-of-range addresses complete with ERR.
module ram_device
  import ram_device_pkg::*;
#(
  parameter int unsigned WordWidth = 32,
  parameter int unsigned Depth     = 4096,
  parameter int unsigned Latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WordWidth-1:0] ram_ctrl_i,
  output logic [WordWidth-1:0] ram_stat_o,
  input  logic [WordWidth-1:0] addr_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [WordWidth-1:0] rdata_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(Latency - 1);

  localparam logic [WordWidth-1:0] StatAck  = WordWidth'(1) << StatAckBit;
  localparam logic [WordWidth-1:0] StatErr  = WordWidth'(1) << StatErrBit;
  localparam logic [WordWidth-1:0] StatBusy = WordWidth'(1) << StatBusyBit;

  state_e               state_q;
  op_e                  op_q;
  logic [WordWidth-1:0] addr_q;
  logic [WordWidth-1:0] wdata_q;
  logic [CntW-1:0]      cnt_q;
  logic [WordWidth-1:0] stat_q;
  logic [WordWidth-1:0] rdata_q;

  logic                 req;
  logic                 in_range;
  logic                 legal;
  logic                 access;
  logic                 mem_we;
  logic [AddrW-1:0]     mem_addr;
  logic [WordWidth-1:0] mem_rdata;
  logic                 unused_ctrl;

  assign req         = ram_ctrl_i[CtrlReadBit] | ram_ctrl_i[CtrlWriteBit];
  assign unused_ctrl = ^ram_ctrl_i[WordWidth-1:CtrlOpBits];

  // Full-width compare: addresses at or above Depth never alias onto the array.
  assign in_range = (addr_q < WordWidth'(Depth));
  assign legal    = in_range && ((op_q == OpRead) || (op_q == OpWrite));
  assign access   = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we   = access && legal && (op_q == OpWrite);

  // The array sees the live address while idle so its registered read is ready even at
  // Latency == 1; afterwards only the captured address is used.
  assign mem_addr = (state_q == StIdle) ? addr_i[AddrW-1:0] : addr_q[AddrW-1:0];

  ram_device_array #(
    .WordWidth(WordWidth),
    .Depth    (Depth),
    .AddrW    (AddrW)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            op_q    <= decode_op(ram_ctrl_i[CtrlReadBit], ram_ctrl_i[CtrlWriteBit]);
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= CntLoad;
            stat_q  <= StatBusy;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            stat_q  <= legal ? StatAck : (StatAck | StatErr);
            rdata_q <= (legal && (op_q == OpRead)) ? mem_rdata : '0;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          // rdata returns to zero with ACK so endpoints can be OR-merged on the bus.
          if (!req) begin
            stat_q  <= '0;
            rdata_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          stat_q  <= '0;
          rdata_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ram_stat_o = stat_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_ram_device.sv
// Directed bench for ram_device: three instances (latency 2, 1, 5) against a transaction-level model.
module tb_ram_device;

  localparam int unsigned W    = 32;
  localparam int unsigned NDut = 3;
  localparam int unsigned LatTab   [NDut] = '{2, 1, 5};
  localparam int unsigned DepthTab [NDut] = '{4096, 16, 16};

  localparam logic [W-1:0] SAck  = 32'h1;
  localparam logic [W-1:0] SErr  = 32'h2;
  localparam logic [W-1:0] SBusy = 32'h4;

  logic         clk;
  logic         rst;
  logic [W-1:0] ctrl      [NDut];
  logic [W-1:0] addr      [NDut];
  logic [W-1:0] wdata     [NDut];
  logic [W-1:0] stat      [NDut];
  logic [W-1:0] rdata     [NDut];
  logic [W-1:0] exp_stat  [NDut];
  logic [W-1:0] exp_rdata [NDut];

  logic [W-1:0] mem_m [longint unsigned];

  int n_checks = 0;
  int n_fail   = 0;

  ram_device #(.WordWidth(W), .Depth(4096), .Latency(2)) u_dut0 (
    .clk(clk), .rst(rst), .ram_ctrl_i(ctrl[0]), .ram_stat_o(stat[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0])
  );
  ram_device #(.WordWidth(W), .Depth(16), .Latency(1)) u_dut1 (
    .clk(clk), .rst(rst), .ram_ctrl_i(ctrl[1]), .ram_stat_o(stat[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1])
  );
  ram_device #(.WordWidth(W), .Depth(16), .Latency(5)) u_dut2 (
    .clk(clk), .rst(rst), .ram_ctrl_i(ctrl[2]), .ram_stat_o(stat[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_rd(input int i, input logic [W-1:0] a);
    longint unsigned key;
    key = (longint'(i) << 32) | longint'(a);
    return mem_m.exists(key) ? mem_m[key] : '0;
  endfunction

  // Cycle-by-cycle comparison of every instance against the model's expected outputs.
  always @(negedge clk) begin
    for (int i = 0; i < NDut; i++) begin
      check($sformatf("stat%0d", i), stat[i], exp_stat[i]);
      check($sformatf("rdata%0d", i), rdata[i], exp_rdata[i]);
    end
  end

  // One handshake; expectations come from the model, observations are returned for literal checks.
  task automatic txn(input int i, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] d, input int hold, input bit abort,
                     output int ack_edge, output int busy_n, output int ack_n,
                     output logic [W-1:0] ack_rdata, output logic [W-1:0] ack_stat);
    int lat;
    bit err;
    longint unsigned key;
    lat      = int'(LatTab[i]);
    ack_edge = 0;
    busy_n   = 0;
    ack_n    = 0;
    @(posedge clk); #1;
    ctrl[i]  = {{(W-2){1'b0}}, op};
    addr[i]  = a;
    wdata[i] = d;
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == lat) begin
        err = (op == 2'b11) || (a >= W'(DepthTab[i]));
        if (!err && op == 2'b10) begin
          key = (longint'(i) << 32) | longint'(a);
          mem_m[key] = d;
        end
        exp_rdata[i] = (!err && op == 2'b01) ? model_rd(i, a) : '0;
        exp_stat[i]  = err ? (SAck | SErr) : SAck;
      end else begin
        exp_stat[i] = SBusy;
      end
      if (stat[i][2]) busy_n++;
      if (stat[i][0] && ack_edge == 0) ack_edge = k;
      if (k == 0) begin
        // Bus activity during BUSY must be ignored.
        addr[i]  = ~a;
        wdata[i] = ~d;
        if (abort) ctrl[i] = '0;
        else if (op != 2'b11) ctrl[i] = {{(W-2){1'b1}}, ~op};
      end
    end
    ack_rdata = rdata[i];
    ack_stat  = stat[i];
    if (stat[i][0]) ack_n++;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (stat[i][0]) ack_n++;
    end
    ctrl[i] = '0;
    @(posedge clk); #1;
    exp_stat[i]  = '0;
    exp_rdata[i] = '0;
    if (stat[i][0]) ack_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int           ae, bn, an;
    logic [W-1:0] ar, as;
    rst = 1'b0;
    for (int i = 0; i < NDut; i++) begin
      ctrl[i] = '0; addr[i] = '0; wdata[i] = '0;
      exp_stat[i] = '0; exp_rdata[i] = '0;
    end
    #1 rst = 1'b1;
    #2;
    check("reset_stat", stat[0], 32'h0);
    check("reset_rdata", rdata[0], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Upper ctrl bits alone must not start a transaction.
    ctrl[0] = 32'hFFFF_FFFC;
    repeat (3) @(posedge clk);
    #1 check("ignored_ctrl_bits", stat[0], 32'h0);
    ctrl[0] = '0;

    txn(0, 2'b10, 32'd5, 32'hDEAD_BEEF, 0, 1'b0, ae, bn, an, ar, as);
    check("wr5_ack_edge", W'(ae), 32'd2);
    check("wr5_busy_cycles", W'(bn), 32'd2);
    check("wr5_stat", as, 32'h1);
    txn(0, 2'b01, 32'd5, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("rd5_ack_edge", W'(ae), 32'd2);
    check("rd5_rdata", ar, 32'hDEAD_BEEF);
    check("rd5_stat", as, 32'h1);

    txn(0, 2'b10, 32'd0, 32'h1234_5678, 0, 1'b0, ae, bn, an, ar, as);
    txn(0, 2'b10, 32'd4096, 32'h0000_CAFE, 0, 1'b0, ae, bn, an, ar, as);
    check("oor_wr_stat", as, 32'h3);
    txn(0, 2'b10, 32'h0001_0000, 32'h0000_0BAD, 0, 1'b0, ae, bn, an, ar, as);
    check("oor_hi_wr_stat", as, 32'h3);
    txn(0, 2'b01, 32'd4096, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("oor_rd_rdata", ar, 32'h0);
    txn(0, 2'b01, 32'd0, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("rd0_after_oor", ar, 32'h1234_5678);

    txn(0, 2'b10, 32'd7, 32'h11, 0, 1'b0, ae, bn, an, ar, as);
    txn(0, 2'b11, 32'd7, 32'h99, 0, 1'b0, ae, bn, an, ar, as);
    check("illegal_stat", as, 32'h3);
    check("illegal_rdata", ar, 32'h0);
    txn(0, 2'b01, 32'd7, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("rd7_after_illegal", ar, 32'h11);

    txn(0, 2'b01, 32'd5, 32'h0, 0, 1'b1, ae, bn, an, ar, as);
    check("abort_ack_cycles", W'(an), 32'd1);
    check("abort_rdata", ar, 32'hDEAD_BEEF);
    txn(0, 2'b01, 32'd7, 32'h0, 10, 1'b0, ae, bn, an, ar, as);
    check("hold_ack_cycles", W'(an), 32'd11);

    // Reset during BUSY discards the pending write.
    txn(0, 2'b10, 32'd9, 32'h22, 0, 1'b0, ae, bn, an, ar, as);
    @(posedge clk); #1;
    ctrl[0] = 32'h2; addr[0] = 32'd9; wdata[0] = 32'h55;
    @(posedge clk); #1;
    exp_stat[0] = SBusy;
    #2;
    rst = 1'b1;
    exp_stat[0] = '0;
    #1 check("rst_async_stat", stat[0], 32'h0);
    ctrl[0] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(0, 2'b01, 32'd9, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("rd9_after_rst", ar, 32'h22);

    txn(1, 2'b10, 32'd3, 32'hA5A5_0001, 0, 1'b0, ae, bn, an, ar, as);
    check("lat1_ack_edge", W'(ae), 32'd1);
    check("lat1_busy_cycles", W'(bn), 32'd1);
    txn(1, 2'b01, 32'd3, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("lat1_rdata", ar, 32'hA5A5_0001);
    txn(2, 2'b10, 32'd15, 32'h5A5A_0002, 0, 1'b0, ae, bn, an, ar, as);
    check("lat5_ack_edge", W'(ae), 32'd5);
    check("lat5_busy_cycles", W'(bn), 32'd5);
    txn(2, 2'b01, 32'd15, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("lat5_rdata", ar, 32'h5A5A_0002);
    txn(2, 2'b10, 32'd16, 32'hFFFF_FFFF, 0, 1'b0, ae, bn, an, ar, as);
    check("lat5_oor_stat", as, 32'h3);
    txn(2, 2'b01, 32'd0, 32'h0, 0, 1'b0, ae, bn, an, ar, as);
    check("lat5_rd0", ar, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
